// File: rtl/array_ram_writer.sv
// Shared result RAM: round-robin write arbitration over per-core 25-byte windows plus a registered read port.
// Optional macro ARRAY_RAM_RD_BYPASS_EN forwards a same-edge write to the read port (write-first).
module array_ram_writer #(
    parameter int NUM_PORTS = 8,
    parameter int WIN_SIZE  = 25,
    parameter int DEPTH     = 200,
    parameter int AW        = 8,
    parameter int DW        = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PORTS-1:0]    wr_req,
    input  logic [NUM_PORTS*AW-1:0] wr_addr,
    input  logic [NUM_PORTS*DW-1:0] wr_data,
    output logic [NUM_PORTS-1:0]    wr_ack,
    output logic [NUM_PORTS-1:0]    wr_err,
    input  logic [AW-1:0]           rd_addr,
    output logic [DW-1:0]           rd_data,
    output logic [15:0]             wr_count
);
    localparam int ABS_W = $clog2(DEPTH) + 1;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    generate
        if (NUM_PORTS * WIN_SIZE > DEPTH) begin : g_depth_check
            $error("array_ram_writer: NUM_PORTS*WIN_SIZE exceeds DEPTH");
        end
    endgenerate

    logic [DW-1:0]        mem [DEPTH];
    logic [AW-1:0]        loc_addr [NUM_PORTS];
    logic [DW-1:0]        loc_data [NUM_PORTS];
    logic [NUM_PORTS-1:0] elig;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]        scan_idx, gnt_idx;
    logic                 gnt_valid, gnt_err, mem_we;
    logic [DW-1:0]        gnt_data;
    logic [ABS_W-1:0]     wr_abs, rd_abs;
    logic [NUM_PORTS-1:0] wr_ack_q, wr_ack_d;
    logic [NUM_PORTS-1:0] wr_err_q, wr_err_d;
    logic [DW-1:0]        rd_data_q, rd_data_d;
    logic [15:0]          wr_count_q, wr_count_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign loc_addr[gi] = wr_addr[AW*gi +: AW];
            assign loc_data[gi] = wr_data[DW*gi +: DW];
            assign wr_ack_d[gi] = gnt_valid && (gnt_idx == PW'(gi));
            assign wr_err_d[gi] = wr_ack_d[gi] && gnt_err;
        end
    endgenerate

    // A core sitting in its ack cycle is not eligible, so it cannot be granted twice in a row.
    assign elig = wr_req & ~wr_ack_q;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        // Scan from farthest to nearest so the closest eligible port at or after rr_ptr wins.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            scan_idx = PW'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (elig[scan_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        gnt_err  = (int'(loc_addr[gnt_idx]) >= WIN_SIZE);
        gnt_data = loc_data[gnt_idx];
        wr_abs   = ABS_W'(WIN_SIZE * int'(gnt_idx)) + ABS_W'(loc_addr[gnt_idx]);
        mem_we   = gnt_valid && !gnt_err;

        rr_ptr_d = rr_ptr_q;
        if (gnt_valid) begin
            rr_ptr_d = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
        end

        wr_count_d = wr_count_q;
        if (mem_we && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end

        rd_abs    = ABS_W'(rd_addr);
        rd_data_d = '0;
        if (rd_abs < ABS_W'(DEPTH)) begin
            rd_data_d = mem[rd_abs[IW-1:0]];
        end
`ifdef ARRAY_RAM_RD_BYPASS_EN
        if (mem_we && (wr_abs == rd_abs)) begin
            rd_data_d = gnt_data;
        end
`endif
    end

    // RAM contents are deliberately untouched by reset; writes are only blocked while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            wr_ack_q   <= '0;
            wr_err_q   <= '0;
            rd_data_q  <= '0;
            wr_count_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wr_ack_q   <= wr_ack_d;
            wr_err_q   <= wr_err_d;
            rd_data_q  <= rd_data_d;
            wr_count_q <= wr_count_d;
            if (mem_we) begin
                mem[wr_abs[IW-1:0]] <= gnt_data;
            end
        end
    end

    assign wr_ack   = wr_ack_q;
    assign wr_err   = wr_err_q;
    assign rd_data  = rd_data_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_array_ram_writer.sv
// Scoreboard bench for array_ram_writer: a per-edge reference model pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_array_ram_writer;
    localparam int N = 8;
    localparam int W = 25;
    localparam int D = 200;

    logic        clk;
    logic        rst_n;
    logic [7:0]  wr_req;
    logic [63:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_ack;
    logic [7:0]  wr_err;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [15:0] wr_count;

    array_ram_writer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .wr_err   (wr_err),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_count (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          edge_no;
        logic [7:0]  ack;
        logic [7:0]  err;
        logic [7:0]  rd;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Requester-side state (what the cores are currently driving)
    logic [7:0] req_s;
    logic [7:0] rda_s;
    logic [7:0] addr_s [N];
    logic [7:0] data_s [N];
    int         mode;   // 0: drop request on ack, 1: keep requesting, 2: random reaction

    // Reference model state
    int         m_ptr;
    logic [7:0] m_ack;
    int         m_cnt;
    logic [7:0] m_mem [D];
    logic [7:0] prev_ack;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic drive_inputs();
        wr_req = req_s;
        for (int i = 0; i < N; i++) begin
            wr_addr[8*i +: 8] = addr_s[i];
            wr_data[8*i +: 8] = data_s[i];
        end
        rd_addr = rda_s;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_ack = '0;
        m_cnt = 0;
    endtask

    function automatic logic [7:0] rand_addr();
        if ($urandom_range(0, 99) < 85) return 8'($urandom_range(0, W - 1));
        return 8'($urandom_range(W, 255));
    endfunction

    // Drive current stimulus, predict the next edge, advance one clock, then react to acks.
    task automatic cycle();
        exp_t       e;
        logic [7:0] elig;
        logic [7:0] nack;
        logic [7:0] nerr;
        int         g;
        int         abs_a;
        drive_inputs();
        elig = req_s & ~m_ack;
        g    = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (g < 0 && elig[c]) g = c;
        end
        nack = '0;
        nerr = '0;
        e.rd = (int'(rda_s) < D) ? m_mem[rda_s] : 8'h00;
        if (g >= 0) begin
            nack[g] = 1'b1;
            m_ptr   = (g + 1) % N;
            if (int'(addr_s[g]) >= W) begin
                nerr[g] = 1'b1;
            end else begin
                abs_a = W * g + int'(addr_s[g]);
`ifdef ARRAY_RAM_RD_BYPASS_EN
                if (abs_a == int'(rda_s)) e.rd = data_s[g];
`endif
                m_mem[abs_a] = data_s[g];
                if (m_cnt < 65535) m_cnt++;
            end
        end
        m_ack     = nack;
        e.edge_no = edge_cnt + 1;
        e.ack     = nack;
        e.err     = nerr;
        e.cnt     = 16'(m_cnt);
        exp_q.push_back(e);
        $display("edge %0d: req=%02h rd_addr=%0d -> expect ack=%02h err=%02h rd=%02h cnt=%0d",
                 e.edge_no, req_s, rda_s, nack, nerr, e.rd, m_cnt);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (nack[i]) begin
                if (mode == 0) begin
                    req_s[i] = 1'b0;
                end else if (mode == 2) begin
                    if ($urandom_range(0, 1) == 0) begin
                        req_s[i] = 1'b0;
                    end else begin
                        addr_s[i] = rand_addr();
                        data_s[i] = 8'($urandom);
                    end
                end
            end
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        req_s = '0;
        drive_inputs();
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard entry for this edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (exp_q.size() > 0 && exp_q[0].edge_no == edge_cnt) begin
                e = exp_q.pop_front();
                check("wr_ack", wr_ack, e.ack);
                check("wr_err", wr_err, e.err);
                check("rd_data", rd_data, e.rd);
                check("wr_count", wr_count, e.cnt);
            end else if (exp_q.size() > 0 && exp_q[0].edge_no < edge_cnt) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_stale: entry for edge %0d never compared (now edge %0d)",
                         exp_q[0].edge_no, edge_cnt);
                void'(exp_q.pop_front());
            end else if (exp_q.size() == 0) begin
                check("unexpected_ack", wr_ack, 32'h0);
            end
            check("ack_onehot0", 32'($onehot0(wr_ack)), 32'h1);
            check("ack_back_to_back", wr_ack & prev_ack, 32'h0);
            prev_ack = wr_ack;
        end else begin
            prev_ack = '0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        req_s    = '0;
        rda_s    = '0;
        mode     = 0;
        prev_ack = '0;
        for (int i = 0; i < N; i++) begin
            addr_s[i] = '0;
            data_s[i] = '0;
        end
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        drive_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_wr_ack", wr_ack, 32'h0);
        check("reset_wr_err", wr_err, 32'h0);
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_wr_count", wr_count, 32'h0);
        rst_n = 1'b1;

        // Single write: core 3, local 4 -> absolute 79
        addr_s[3] = 8'd4;
        data_s[3] = 8'hA5;
        req_s     = 8'h08;
        cycle();
        rda_s = 8'd79;
        cycle();
        rda_s = 8'd0;
        cycle();

        // All cores requesting from rr_ptr = 0
        reset_pulse();
        for (int i = 0; i < N; i++) begin
            addr_s[i] = 8'($urandom_range(1, W - 1));
            data_s[i] = 8'($urandom);
        end
        req_s = 8'hFF;
        mode  = 1;
        repeat (20) cycle();
        mode  = 0;
        req_s = '0;
        cycle();

        // Wrap search: grant core 5 so rr_ptr = 6, then cores 2 and 7 compete
        addr_s[5] = 8'd2;
        data_s[5] = 8'h55;
        req_s     = 8'h20;
        cycle();
        addr_s[2] = 8'd3;
        data_s[2] = 8'h22;
        addr_s[7] = 8'd4;
        data_s[7] = 8'h77;
        req_s     = 8'h84;
        repeat (3) cycle();

        // Window error: core 0 local 25 must not touch absolute 25
        rda_s     = 8'd25;
        addr_s[0] = 8'd25;
        data_s[0] = 8'h11;
        req_s     = 8'h01;
        repeat (2) cycle();

        // Same-edge read/write collision on absolute 25
        addr_s[1] = 8'd0;
        data_s[1] = 8'h3C;
        req_s     = 8'h02;
        repeat (2) cycle();

        // Randomized traffic
        mode = 2;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_s[i] && $urandom_range(0, 99) < 30) begin
                    req_s[i]  = 1'b1;
                    addr_s[i] = rand_addr();
                    data_s[i] = 8'($urandom);
                end
            end
            if ($urandom_range(0, 99) < 30) begin
                int c;
                c     = $urandom_range(0, N - 1);
                rda_s = 8'(W * c + int'(addr_s[c]));
            end else begin
                rda_s = 8'($urandom_range(0, 255));
            end
            cycle();
        end
        mode  = 0;
        req_s = '0;
        cycle();

        // Asynchronous reset while core 2 re-requests in its ack cycle and core 5 is pending
        addr_s[2] = 8'd7;
        data_s[2] = 8'h5A;
        req_s     = 8'h04;
        rda_s     = 8'd57;
        cycle();
        rda_s     = 8'd57;
        addr_s[2] = 8'd8;
        data_s[2] = 8'hB4;
        addr_s[5] = 8'd9;
        data_s[5] = 8'hC3;
        req_s     = 8'h24;
        drive_inputs();
        rst_n = 1'b0;
        #1;
        check("async_rst_wr_ack", wr_ack, 32'h0);
        check("async_rst_wr_err", wr_err, 32'h0);
        check("async_rst_rd_data", rd_data, 32'h0);
        check("async_rst_wr_count", wr_count, 32'h0);
        exp_q.delete();
        model_reset();
        #1;
        rst_n = 1'b1;
        repeat (3) cycle();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
